// File: rtl/mio_ram16_arbiter.sv
// mio_ram16_arbiter: shares one 16-bit synchronous RAM between the multicycle
// CPU controller and the IO polling engine. Word accesses are split into two
// halfword beats (low then high); halfword accesses use a single beat.
// Optional feature macro: ARB_ROUND_ROBIN_EN (alternate winner on a tie).
module mio_ram16_arbiter #(
    parameter int unsigned RAM_AW  = 12,
    parameter int unsigned RAM_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic              cpu_half,
    input  logic [31:0]       cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic [31:0]       cpu_rdata,
    output logic              cpu_ready,
    input  logic              io_req,
    input  logic              io_we,
    input  logic              io_half,
    input  logic [31:0]       io_addr,
    input  logic [31:0]       io_wdata,
    output logic [31:0]       io_rdata,
    output logic              io_ready,
    output logic              ram_en,
    output logic              ram_we,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [15:0]       ram_din,
    input  logic [15:0]       ram_dout,
    output logic              busy,
    output logic              grant_io
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic              r_we;
    logic              r_half;
    logic              r_beat;
    logic              r_grant_io;
    logic [2:0]        r_lat;
    logic [RAM_AW-1:0] r_ram_addr;
    logic [15:0]       r_ram_din;
    logic [15:0]       r_wdata_hi;
    logic [15:0]       r_lo_buf;
    logic [31:0]       r_cpu_rdata;
    logic [31:0]       r_io_rdata;
`ifdef ARB_ROUND_ROBIN_EN
    logic              r_last_io;
`endif

    logic              w_sel_io;
    logic              w_req_any;
    logic              w_req_we;
    logic              w_req_half;
    logic [31:0]       w_req_addr;
    logic [31:0]       w_req_wdata;
    logic [RAM_AW-1:0] w_first_addr;
    logic              w_last_wait;
    logic              w_more;
    logic              w_grant;
    logic              w_hi_issue;
    logic              w_capture;
    logic              w_unused_addr_bits;

    // Only addr[RAM_AW:1] matters; the remaining address bits are don't-care.
    assign w_unused_addr_bits = ^{cpu_addr, io_addr};

    // Arbitration and selection of the winning requester's fields.
    always_comb begin
        w_req_any = cpu_req | io_req;
`ifdef ARB_ROUND_ROBIN_EN
        w_sel_io  = io_req & (~cpu_req | ~r_last_io);
`else
        w_sel_io  = io_req & ~cpu_req;
`endif
        w_req_we    = w_sel_io ? io_we    : cpu_we;
        w_req_half  = w_sel_io ? io_half  : cpu_half;
        w_req_addr  = w_sel_io ? io_addr  : cpu_addr;
        w_req_wdata = w_sel_io ? io_wdata : cpu_wdata;
        // Word accesses ignore addr[1] and always start at the even halfword.
        w_first_addr = {w_req_addr[RAM_AW:2], w_req_half & w_req_addr[1]};
    end

    // Next-state logic and output decode.
    always_comb begin
        w_next      = r_state;
        w_grant     = 1'b0;
        w_hi_issue  = 1'b0;
        w_capture   = 1'b0;
        w_last_wait = (r_lat == 3'(RAM_LAT - 1));
        w_more      = ~r_half & ~r_beat;
        case (r_state)
            S_IDLE: begin
                if (w_req_any) begin
                    w_grant = 1'b1;
                    w_next  = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (r_we) begin
                    w_hi_issue = w_more;
                    w_next     = w_more ? S_ISSUE : S_DONE;
                end else begin
                    w_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (w_last_wait) begin
                    w_capture  = 1'b1;
                    w_hi_issue = w_more;
                    w_next     = w_more ? S_ISSUE : S_DONE;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
        ram_en    = (r_state == S_ISSUE);
        ram_we    = (r_state == S_ISSUE) & r_we;
        cpu_ready = (r_state == S_DONE) & ~r_grant_io;
        io_ready  = (r_state == S_DONE) & r_grant_io;
        busy      = (r_state != S_IDLE);
    end

    // State register plus transfer context, beat/latency counters and read data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_we        <= 1'b0;
            r_half      <= 1'b0;
            r_beat      <= 1'b0;
            r_grant_io  <= 1'b0;
            r_lat       <= '0;
            r_ram_addr  <= '0;
            r_ram_din   <= '0;
            r_wdata_hi  <= '0;
            r_lo_buf    <= '0;
            r_cpu_rdata <= '0;
            r_io_rdata  <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            r_last_io   <= 1'b1;
`endif
        end else begin
            r_state <= w_next;
            if (w_grant) begin
                r_grant_io <= w_sel_io;
                r_we       <= w_req_we;
                r_half     <= w_req_half;
                r_beat     <= 1'b0;
                r_ram_addr <= w_first_addr;
                r_ram_din  <= w_req_wdata[15:0];
                r_wdata_hi <= w_req_wdata[31:16];
`ifdef ARB_ROUND_ROBIN_EN
                r_last_io  <= w_sel_io;
`endif
            end
            if (w_hi_issue) begin
                r_beat     <= 1'b1;
                r_ram_addr <= {r_ram_addr[RAM_AW-1:1], 1'b1};
                r_ram_din  <= r_wdata_hi;
            end
            if (r_state == S_ISSUE) begin
                r_lat <= '0;
            end else if ((r_state == S_WAIT) && !w_last_wait) begin
                r_lat <= r_lat + 3'd1;
            end
            // Low beat of a word read is staged so rdata changes only once,
            // when the whole word is available.
            if (w_capture) begin
                if (r_half || r_beat) begin
                    if (r_grant_io) begin
                        r_io_rdata <= r_half ? {16'h0000, ram_dout} : {ram_dout, r_lo_buf};
                    end else begin
                        r_cpu_rdata <= r_half ? {16'h0000, ram_dout} : {ram_dout, r_lo_buf};
                    end
                end else begin
                    r_lo_buf <= ram_dout;
                end
            end
        end
    end

    assign ram_addr  = r_ram_addr;
    assign ram_din   = r_ram_din;
    assign cpu_rdata = r_cpu_rdata;
    assign io_rdata  = r_io_rdata;
    assign grant_io  = r_grant_io;

endmodule

// File: tb/tb_mio_ram16_arbiter.sv
// Directed self-checking bench for mio_ram16_arbiter. Instance u_dut uses
// RAM_LAT=1, instance u_dut3 uses RAM_LAT=3; each has its own RAM model.
module tb_mio_ram16_arbiter;

    logic        clk = 1'b0;
    logic        reset;

    logic        cpu_req, cpu_we, cpu_half;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        cpu_ready;
    logic        io_req, io_we, io_half;
    logic [31:0] io_addr, io_wdata, io_rdata;
    logic        io_ready;
    logic        ram_en, ram_we;
    logic [11:0] ram_addr;
    logic [15:0] ram_din, ram_dout;
    logic        busy, grant_io;

    logic        b_io_req, b_io_we, b_io_half;
    logic [31:0] b_io_addr, b_io_wdata, b_io_rdata;
    logic        b_io_ready;
    logic [31:0] b_unused_cpu_rdata;
    logic        b_unused_cpu_ready;
    logic        b_ram_en, b_ram_we;
    logic [11:0] b_ram_addr;
    logic [15:0] b_ram_din, b_ram_dout;
    logic        b_busy, b_grant_io;

    int total = 0;
    int bad   = 0;

    logic [15:0] mem_a [0:4095];
    logic [15:0] mem_b [0:4095];
    logic [15:0] b_p1, b_p2, b_p3;

    logic [11:0] log_addr [0:63];
    logic [15:0] log_din  [0:63];
    logic        log_we   [0:63];
    int          n_beats   = 0;
    int          n_cpu_rdy = 0;
    int          n_io_rdy  = 0;

    always #5 clk = ~clk;

    mio_ram16_arbiter #(.RAM_AW(12), .RAM_LAT(1)) u_dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_half(cpu_half),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
        .io_req(io_req), .io_we(io_we), .io_half(io_half),
        .io_addr(io_addr), .io_wdata(io_wdata), .io_rdata(io_rdata), .io_ready(io_ready),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
        .ram_dout(ram_dout), .busy(busy), .grant_io(grant_io)
    );

    mio_ram16_arbiter #(.RAM_AW(12), .RAM_LAT(3)) u_dut3 (
        .clk(clk), .reset(reset),
        .cpu_req(1'b0), .cpu_we(1'b0), .cpu_half(1'b0),
        .cpu_addr(32'h0), .cpu_wdata(32'h0), .cpu_rdata(b_unused_cpu_rdata),
        .cpu_ready(b_unused_cpu_ready),
        .io_req(b_io_req), .io_we(b_io_we), .io_half(b_io_half),
        .io_addr(b_io_addr), .io_wdata(b_io_wdata), .io_rdata(b_io_rdata), .io_ready(b_io_ready),
        .ram_en(b_ram_en), .ram_we(b_ram_we), .ram_addr(b_ram_addr), .ram_din(b_ram_din),
        .ram_dout(b_ram_dout), .busy(b_busy), .grant_io(b_grant_io)
    );

    // RAM model, one cycle read latency
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) mem_a[ram_addr] <= ram_din;
            ram_dout <= mem_a[ram_addr];
        end
    end

    // RAM model, three cycle read latency
    always @(posedge clk) begin
        if (b_ram_en) begin
            if (b_ram_we) mem_b[b_ram_addr] <= b_ram_din;
            b_p1 <= mem_b[b_ram_addr];
        end
        b_p2 <= b_p1;
        b_p3 <= b_p2;
    end
    assign b_ram_dout = b_p3;

    // Beat log and ready-pulse counters for u_dut
    always @(negedge clk) begin
        if (ram_en && n_beats < 64) begin
            log_addr[n_beats] <= ram_addr;
            log_din[n_beats]  <= ram_din;
            log_we[n_beats]   <= ram_we;
            n_beats           <= n_beats + 1;
        end
        if (cpu_ready) n_cpu_rdy <= n_cpu_rdy + 1;
        if (io_ready)  n_io_rdy  <= n_io_rdy + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic rdy(input int sel);
        if (sel == 0) return cpu_ready;
        if (sel == 1) return io_ready;
        return b_io_ready;
    endfunction

    task automatic wait_rdy(input int sel, output int cyc);
        cyc = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (rdy(sel)) begin
                cyc = k;
                return;
            end
        end
    endtask

    // One complete transfer: raise req, measure latency, drop req after ready.
    task automatic xfer(input int sel, input logic we, input logic half,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input int exp_lat, input string tag);
        int cyc;
        if (sel == 0) begin
            cpu_we = we; cpu_half = half; cpu_addr = addr; cpu_wdata = wdata; cpu_req = 1'b1;
        end else if (sel == 1) begin
            io_we = we; io_half = half; io_addr = addr; io_wdata = wdata; io_req = 1'b1;
        end else begin
            b_io_we = we; b_io_half = half; b_io_addr = addr; b_io_wdata = wdata; b_io_req = 1'b1;
        end
        wait_rdy(sel, cyc);
        check({tag, "_lat"}, cyc, exp_lat);
        cpu_req  = 1'b0;
        io_req   = 1'b0;
        b_io_req = 1'b0;
        @(negedge clk);
        check({tag, "_rdy_pulse"}, {31'b0, rdy(sel)}, 32'd0);
        check({tag, "_idle"}, {31'b0, (sel == 2) ? b_busy : busy}, 32'd0);
    endtask

    int        base;
    int        cnt;
    int        found;
    logic [3:0] exp_arb;

    initial begin
        reset = 1'b1;
        cpu_req = 0; cpu_we = 0; cpu_half = 0; cpu_addr = 0; cpu_wdata = 0;
        io_req = 0; io_we = 0; io_half = 0; io_addr = 0; io_wdata = 0;
        b_io_req = 0; b_io_we = 0; b_io_half = 0; b_io_addr = 0; b_io_wdata = 0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // reset state
        check("rst_ram_en",    {31'b0, ram_en},    32'd0);
        check("rst_ram_we",    {31'b0, ram_we},    32'd0);
        check("rst_ram_addr",  {20'b0, ram_addr},  32'd0);
        check("rst_ram_din",   {16'b0, ram_din},   32'd0);
        check("rst_cpu_ready", {31'b0, cpu_ready}, 32'd0);
        check("rst_io_ready",  {31'b0, io_ready},  32'd0);
        check("rst_cpu_rdata", cpu_rdata,          32'd0);
        check("rst_io_rdata",  io_rdata,           32'd0);
        check("rst_busy",      {31'b0, busy},      32'd0);
        check("rst_grant_io",  {31'b0, grant_io},  32'd0);
        check("rst_b_busy",    {31'b0, b_busy},    32'd0);

        // CPU word write 0x10 <- 0xDEADBEEF
        base = n_beats;
        xfer(0, 1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 3, "wwr");
        check("wwr_beats",  n_beats - base,              32'd2);
        check("wwr_addr0",  {20'b0, log_addr[base]},     32'h8);
        check("wwr_din0",   {16'b0, log_din[base]},      32'hBEEF);
        check("wwr_we0",    {31'b0, log_we[base]},       32'd1);
        check("wwr_addr1",  {20'b0, log_addr[base + 1]}, 32'h9);
        check("wwr_din1",   {16'b0, log_din[base + 1]},  32'hDEAD);
        check("wwr_grant",  {31'b0, grant_io},           32'd0);

        // CPU word read 0x10
        base = n_beats;
        xfer(0, 1'b0, 1'b0, 32'h10, 32'h0, 5, "wrd");
        check("wrd_data",   cpu_rdata,                   32'hDEADBEEF);
        check("wrd_beats",  n_beats - base,              32'd2);
        check("wrd_addr0",  {20'b0, log_addr[base]},     32'h8);
        check("wrd_addr1",  {20'b0, log_addr[base + 1]}, 32'h9);
        check("wrd_we0",    {31'b0, log_we[base]},       32'd0);
        check("wrd_io_rdy", n_io_rdy,                    32'd0);

        // IO halfword read 0x12
        base = n_beats;
        xfer(1, 1'b0, 1'b1, 32'h12, 32'h0, 3, "hrd");
        check("hrd_data",   io_rdata,                    32'h0000DEAD);
        check("hrd_beats",  n_beats - base,              32'd1);
        check("hrd_addr",   {20'b0, log_addr[base]},     32'h9);
        check("hrd_grant",  {31'b0, grant_io},           32'd1);
        check("hrd_cpu_kept", cpu_rdata,                 32'hDEADBEEF);
        check("hrd_cpu_rdy", n_cpu_rdy,                  32'd2);

        // word read with addr[1] set still starts at the even halfword
        base = n_beats;
        xfer(0, 1'b0, 1'b0, 32'h12, 32'h0, 5, "wrd12");
        check("wrd12_addr0", {20'b0, log_addr[base]},    32'h8);
        check("wrd12_data",  cpu_rdata,                  32'hDEADBEEF);

        // halfword write ignoring addr[0] and bits above RAM_AW
        base = n_beats;
        xfer(0, 1'b1, 1'b1, 32'h0001_2015, 32'hFFFF1234, 2, "hwr");
        check("hwr_beats", n_beats - base,               32'd1);
        check("hwr_addr",  {20'b0, log_addr[base]},      32'hA);
        check("hwr_din",   {16'b0, log_din[base]},       32'h1234);
        xfer(0, 1'b0, 1'b1, 32'h10, 32'h0, 3, "hrd10");
        check("hrd10_data", cpu_rdata,                   32'h0000BEEF);
        xfer(1, 1'b0, 1'b1, 32'h14, 32'h0, 3, "hrd14");
        check("hrd14_data", io_rdata,                    32'h00001234);

        // tie arbitration over four back-to-back transfers
`ifdef ARB_ROUND_ROBIN_EN
        exp_arb = 4'b1010;
`else
        exp_arb = 4'b0000;
`endif
        cpu_we = 1'b1; cpu_half = 1'b1; cpu_addr = 32'h20; cpu_wdata = 32'h1111;
        io_we  = 1'b1; io_half  = 1'b1; io_addr  = 32'h30; io_wdata  = 32'h2222;
        cpu_req = 1'b1;
        io_req  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            found = 0;
            for (int k = 0; k < 20 && found == 0; k++) begin
                @(posedge clk);
                @(negedge clk);
                if (cpu_ready || io_ready) found = 1;
            end
            check($sformatf("arb%0d_seen", i),  found,                   32'd1);
            check($sformatf("arb%0d_io", i),    {31'b0, io_ready},       {31'b0, exp_arb[i]});
            check($sformatf("arb%0d_grant", i), {31'b0, grant_io},       {31'b0, exp_arb[i]});
        end
        cpu_req = 1'b0;
        io_req  = 1'b0;
        @(negedge clk);
        check("arb_idle", {31'b0, busy}, 32'd0);

        // reset during the wait of the high beat of a word read
        cpu_we = 1'b0; cpu_half = 1'b0; cpu_addr = 32'h10; cpu_req = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("mid_busy", {31'b0, busy},     32'd1);
        check("mid_addr", {20'b0, ram_addr}, 32'h9);
        check("mid_en",   {31'b0, ram_en},   32'd0);
        cnt = n_cpu_rdy;
        reset   = 1'b1;
        cpu_req = 1'b0;
        @(negedge clk);
        check("mrst_ram_en",    {31'b0, ram_en},    32'd0);
        check("mrst_ram_addr",  {20'b0, ram_addr},  32'd0);
        check("mrst_ram_din",   {16'b0, ram_din},   32'd0);
        check("mrst_cpu_rdata", cpu_rdata,          32'd0);
        check("mrst_io_rdata",  io_rdata,           32'd0);
        check("mrst_busy",      {31'b0, busy},      32'd0);
        check("mrst_grant_io",  {31'b0, grant_io},  32'd0);
        check("mrst_cpu_ready", {31'b0, cpu_ready}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("mrst_no_pulse", n_cpu_rdy - cnt, 32'd0);
        xfer(0, 1'b1, 1'b1, 32'h40, 32'h5555, 2, "post_rst_hwr");

        // RAM_LAT = 3 instance: IO halfword write then read of 0x12
        xfer(2, 1'b1, 1'b1, 32'h12, 32'h0000DEAD, 2, "lat3_hwr");
        xfer(2, 1'b0, 1'b1, 32'h12, 32'h0, 5, "lat3_hrd");
        check("lat3_data",  b_io_rdata,              32'h0000DEAD);
        check("lat3_grant", {31'b0, b_grant_io},     32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
